instr_mem: RTL

Parametrised, synchronous instruction memory. It replaces the fixed combinational program table in the CPU fetch path.
- Read port: registered, 1-cycle latency, with a valid flag.
- Program (write) port: lets a loader or testbench write the program at runtime.
- Post-reset clear sequence: zero-fills every word before fetch is allowed, so unwritten addresses read as all-zero (NOP), matching the old default-zero behaviour.

---
 rtl/instr_mem.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_mem.sv
// instr_mem: synchronous instruction memory, zero-filled after reset, 1-cycle registered read.
// Optional macro INSTR_MEM_PARITY_EN adds a stored even-parity bit per word and a par_err output.
module instr_mem #(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef INSTR_MEM_PARITY_EN
  output logic              par_err,
`endif
  output logic              addr_err
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  // Extra MSB keeps the compare correct when DEPTH == 2^ADDR_W (always in range).
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clr_we;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_rd_in;
  logic              w_wr_in;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_same_addr;
  logic [DATA_W-1:0] w_rd_word;

  logic              r_rd_vld_p1;
  logic [DATA_W-1:0] r_rd_data_p1;
  logic              r_addr_err_p1;

  assign w_rd_in     = in_range(rd_addr);
  assign w_wr_in     = in_range(wr_addr);
  assign w_rd_idx    = rd_addr[IDX_W-1:0];
  assign w_wr_idx    = wr_addr[IDX_W-1:0];
  assign w_same_addr = w_wr_acc && w_wr_in && (wr_addr == rd_addr);
  // Write-first: a same-address write in this cycle bypasses the array.
  assign w_rd_word   = w_same_addr ? wr_data : r_mem[w_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_cnt == LAST_IDX) w_state_nxt = S_READY;
      end
      S_READY: begin
        w_rd_acc = rd_en;
        w_wr_acc = wr_en;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           r_cnt <= '0;
    else if (w_clr_we) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we)                r_mem[r_cnt]    <= '0;
      else if (w_wr_acc && w_wr_in) r_mem[w_wr_idx] <= wr_data;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic r_par [DEPTH];
  logic w_rd_par;
  logic r_par_err_p1;

  assign w_rd_par = w_same_addr ? even_par(wr_data) : r_par[w_rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we)                r_par[r_cnt]    <= 1'b0;
      else if (w_wr_acc && w_wr_in) r_par[w_wr_idx] <= even_par(wr_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_par_err_p1 <= 1'b0;
    else     r_par_err_p1 <= w_rd_acc && w_rd_in && (even_par(w_rd_word) != w_rd_par);
  end

  assign par_err = r_par_err_p1;
`endif

  // p0 -> p1: registered read response; rd_data holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld_p1   <= 1'b0;
      r_rd_data_p1  <= '0;
      r_addr_err_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1   <= w_rd_acc;
      r_addr_err_p1 <= (w_rd_acc && !w_rd_in) || (w_wr_acc && !w_wr_in);
      if (w_rd_acc) r_rd_data_p1 <= w_rd_in ? w_rd_word : '0;
    end
  end

  assign ready    = (r_state == S_READY);
  assign rd_valid = r_rd_vld_p1;
  assign rd_data  = r_rd_data_p1;
  assign addr_err = r_addr_err_p1;

endmodule
